mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port and the load/store (MEM-stage) port of the core.
- Grants one requester at a time, with data priority and a starvation guard for fetch.
- Sequences each access through issue, fixed-latency wait and response.
- Converts the MEM_* op encoding into byte enables, store-lane replication and load sign/zero extension, and flags misaligned data accesses.

Parameters:
- RD_LATENCY, 1, cycles from mem_req high to mem_rdata valid; legal range 1..7.
- STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before fetch is forced; legal range 1..15.
- DATA_WIDTH / ADDR_WIDTH, 32 / 32, taken from my_pkg.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request; held high with fields stable until d_ack.
- d_op  in  3  MEM_LB..MEM_SW encoding.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  extended load result; 0 for stores and on error.
- d_err  out  1  valid with d_ack; misaligned access, no memory cycle issued.
- mem_req  out  1  one-cycle memory strobe.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid RD_LATENCY cycles after mem_req.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, streak counter 0, latched request cleared.
- Reset asserted mid-access abandons the access. No ack is produced, and a late mem_rdata is ignored.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the requests. Grants data if d_req is high, unless i_req is high and streak == STARVE_LIMIT, in which case fetch is granted.
  - On grant, latches port fields and owner.
  - A misaligned data request goes directly to RESP with d_err=1 and no memory cycle. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- ISSUE: exactly 1 cycle; mem_req=1 and memory fields driven.
- WAIT: exactly RD_LATENCY cycles, tracked by a 3-bit counter. mem_rdata is captured in the final WAIT cycle for both reads and writes (writes use uniform timing).
- RESP: exactly 1 cycle; the owner's ack=1 with its rdata and err; then IDLE.
- Latency: request seen in IDLE cycle N gives mem_req at N+1 and ack at N+2+RD_LATENCY (N+3 at default). A misaligned request acks at N+1.
- Requester rules:
  - A requester must drop or replace req in the cycle after ack.
  - In RESP the FSM ignores requests, so the same request is never re-granted.
  - Back-to-back throughput is 1 access per 3+RD_LATENCY cycles.
- Streak counter:
  - Increments on a data grant while i_req=1.
  - Clears on any fetch grant, or on a data grant with i_req=0.
  - Saturates at STARVE_LIMIT.
- Stores, mem_we=1:
  - SB: be=1<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011 or 1100 by addr[1], wdata={2{half}}.
  - SW: be=1111.
- Loads and fetch: mem_we=0, be=1111.
- Load extraction uses latched addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Outputs on unowned channel: the unowned ack stays 0, and the non-owner's rdata holds its previous value.

Decomposition:
- my_pkg additions:
  - typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - parameter ARB_OWNER_I=1'b0, ARB_OWNER_D=1'b1.
  - Reuse the existing MEM_* op encodings.
- Sub-module lsu_align, purely combinational. Inputs op, addr[1:0], wdata, rdata. Outputs be, lane wdata, extended rdata, misaligned. It is shared with any future cache path.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, memory word 0xDEADBEEF -> mem_req at cycle 1, i_ack at cycle 3, i_rdata=0xDEADBEEF, mem_we=0, be=1111.
- d_req SB addr=0x203, wdata=0x000000A5 -> mem_addr=0x200, be=1000, mem_wdata=0xA5A5A5A5, we=1, d_ack at N+3, d_rdata=0.
- LB addr=0x201, word=0x0000F000 -> d_rdata=0xFFFFFFF0. LBU same -> 0x000000F0. LH addr=0x202, word=0x80000000 -> 0xFFFF8000.
- LW addr=0x202 -> d_ack and d_err at N+1, mem_req never asserted, d_rdata=0.
- i_req held high with 6 consecutive data requests, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D.
- rst pulsed during WAIT -> all outputs 0 immediately, FSM IDLE, no ack. A re-issued request then completes normally with the correct data.

Source files
------------

// File: rtl/my_pkg.sv
`default_nettype none
// my_pkg: shared core types, memory-op encodings and arbiter definitions.
// Rev 1.0
package my_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  function automatic logic op_is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// lsu_align: byte enables, store lane replication, load extension, misalignment.
// Rev 1.0
module lsu_align
  import my_pkg::*;
(
  input  logic [2:0]            op,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] lane_wdata,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr, 3'b000} +: 8];
  assign rd_half = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    ext_rdata  = rdata;
    misaligned = 1'b0;
    case (mem_op_t'(op))
      MEM_LB:  ext_rdata = {{24{rd_byte[7]}}, rd_byte};
      MEM_LBU: ext_rdata = {24'd0, rd_byte};
      MEM_LH: begin
        ext_rdata  = {{16{rd_half[15]}}, rd_half};
        misaligned = addr[0];
      end
      MEM_LHU: begin
        ext_rdata  = {16'd0, rd_half};
        misaligned = addr[0];
      end
      MEM_LW:  misaligned = |addr;
      MEM_SB: begin
        be         = 4'b0001 << addr;
        lane_wdata = {4{wdata[7:0]}};
      end
      MEM_SH: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      MEM_SW:  misaligned = |addr;
      default: misaligned = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one single-port memory between fetch and load/store.
// Rev 1.0
module mem_port_arbiter
  import my_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [2:0]            d_op,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  mem_op_t               op_q, op_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            streak_q, streak_d;
  logic                  i_ack_q, i_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  grant_data;
  logic [2:0]            align_op;
  logic [1:0]            align_addr;
  logic [3:0]            align_be;
  logic [DATA_WIDTH-1:0] align_wdata, align_rdata;
  logic                  align_mis;
  logic                  unused_i_addr;

  assign unused_i_addr = ^i_addr[1:0];

  // Live request fields drive the aligner while granting; latched fields afterwards.
  assign align_op   = (state_q == ARB_IDLE) ? d_op : op_q;
  assign align_addr = (state_q == ARB_IDLE) ? d_addr[1:0] : addr_lo_q;
  assign grant_data = d_req && !(i_req && (streak_q == 4'(STARVE_LIMIT)));

  lsu_align u_align (
    .op         (align_op),
    .addr       (align_addr),
    .wdata      (d_wdata),
    .rdata      (mem_rdata),
    .be         (align_be),
    .lane_wdata (align_wdata),
    .ext_rdata  (align_rdata),
    .misaligned (align_mis)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_data) begin
          owner_d   = ARB_OWNER_D;
          op_d      = mem_op_t'(d_op);
          addr_lo_d = d_addr[1:0];
          if (!i_req)
            streak_d = 4'd0;
          else if (streak_q != 4'(STARVE_LIMIT))
            streak_d = streak_q + 4'd1;
          if (align_mis) begin
            state_d   = ARB_RESP;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d     = ARB_ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = op_is_store(mem_op_t'(d_op));
            mem_be_d    = align_be;
            mem_addr_d  = {d_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = align_wdata;
          end
        end else if (i_req) begin
          owner_d    = ARB_OWNER_I;
          streak_d   = 4'd0;
          state_d    = ARB_ISSUE;
          mem_req_d  = 1'b1;
          mem_be_d   = 4'b1111;
          mem_addr_d = {i_addr[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        cnt_d   = 3'd1;
      end
      ARB_WAIT: begin
        if (cnt_q == 3'(RD_LATENCY)) begin
          // Ack is registered here so it is visible during the RESP cycle.
          state_d = ARB_RESP;
          if (owner_q == ARB_OWNER_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = op_is_store(op_q) ? '0 : align_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWNER_I;
      op_q        <= MEM_LB;
      addr_lo_q   <= 2'b00;
      cnt_q       <= 3'd0;
      streak_q    <= 4'd0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Rev 1.0
module tb_mem_port_arbiter;
  import my_pkg::*;

  localparam int RDL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [2:0]  d_op = 3'd0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [31:0] mem_word = '0;
  logic [7:0]  pipe;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Read word is only valid exactly RDL cycles after the strobe.
  always @(posedge clk or posedge rst)
    if (rst) pipe <= '0;
    else     pipe <= {pipe[6:0], mem_req};
  assign mem_rdata = pipe[RDL-1] ? mem_word : 32'hBADC0DE5;

  mem_port_arbiter #(.RD_LATENCY(RDL), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic do_data(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] word, output int req_c, output int ack_c,
                         output logic [31:0] rd, output logic err, output logic we,
                         output logic [3:0] be, output logic [31:0] ma, output logic [31:0] mw);
    req_c = -1; ack_c = -1; rd = 32'hxxxxxxxx; err = 1'bx; we = 1'b0; be = 4'h0; ma = '0; mw = '0;
    mem_word = word; d_op = op; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    for (int c = 1; c <= 12 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (mem_req && req_c < 0) begin
        req_c = c; we = mem_we; be = mem_be; ma = mem_addr; mw = mem_wdata;
      end
      if (d_ack) begin
        ack_c = c; rd = d_rdata; err = d_err; d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    @(posedge clk); #1;
    if (mem_req && req_c < 0) req_c = 99;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, output int req_c,
                          output int ack_c, output logic [31:0] rd, output logic we,
                          output logic [3:0] be, output logic [31:0] ma);
    req_c = -1; ack_c = -1; rd = 32'hxxxxxxxx; we = 1'bx; be = 4'h0; ma = '0;
    mem_word = word; i_addr = addr; i_req = 1'b1;
    for (int c = 1; c <= 12 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (mem_req && req_c < 0) begin
        req_c = c; we = mem_we; be = mem_be; ma = mem_addr;
      end
      if (i_ack) begin
        ack_c = c; rd = i_rdata; i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL reset_i_ack got %b want 0", i_ack); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({i_rdata, d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", {i_rdata, d_rdata}); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata, d_err} !== 70'd0) begin errors++; $display("FAIL reset_mem_fields got %h want 0", {mem_we, mem_be, mem_addr, mem_wdata, d_err}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int rc, ac; logic [31:0] rd, ma; logic we; logic [3:0] be;
    do_fetch(32'h100, 32'hDEADBEEF, rc, ac, rd, we, be, ma);
    checks++; if (rc !== 1) begin errors++; $display("FAIL fetch_req_cycle got %0d want 1", rc); end
    checks++; if (ac !== 3) begin errors++; $display("FAIL fetch_ack_cycle got %0d want 3", ac); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %h want deadbeef", rd); end
    checks++; if ({we, be} !== 5'b01111) begin errors++; $display("FAIL fetch_we_be got %b want 01111", {we, be}); end
    checks++; if (ma !== 32'h100) begin errors++; $display("FAIL fetch_addr got %h want 00000100", ma); end
  endtask

  task automatic test_stores();
    int rc, ac; logic [31:0] rd, ma, mw; logic err, we; logic [3:0] be;
    do_data(MEM_SB, 32'h203, 32'h000000A5, 32'h0, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (ma !== 32'h200) begin errors++; $display("FAIL sb_addr got %h want 00000200", ma); end
    checks++; if ({we, be} !== 5'b11000) begin errors++; $display("FAIL sb_we_be got %b want 11000", {we, be}); end
    checks++; if (mw !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", mw); end
    checks++; if (ac !== 3) begin errors++; $display("FAIL sb_ack_cycle got %0d want 3", ac); end
    checks++; if ({err, rd} !== 33'd0) begin errors++; $display("FAIL sb_rdata_err got %h want 0", {err, rd}); end
    do_data(MEM_SH, 32'h202, 32'h00001234, 32'h0, rc, ac, rd, err, we, be, ma, mw);
    checks++; if ({we, be, mw} !== {1'b1, 4'b1100, 32'h12341234}) begin errors++; $display("FAIL sh_fields got %b %b %h want 1 1100 12341234", we, be, mw); end
    do_data(MEM_SW, 32'h204, 32'hCAFEF00D, 32'h0, rc, ac, rd, err, we, be, ma, mw);
    checks++; if ({we, be, ma, mw} !== {1'b1, 4'b1111, 32'h204, 32'hCAFEF00D}) begin errors++; $display("FAIL sw_fields got %b %b %h %h want 1 1111 00000204 cafef00d", we, be, ma, mw); end
  endtask

  task automatic test_loads();
    int rc, ac; logic [31:0] rd, ma, mw; logic err, we; logic [3:0] be;
    do_data(MEM_LB, 32'h201, 32'h0, 32'h0000F000, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_rdata got %h want fffffff0", rd); end
    checks++; if ({we, be} !== 5'b01111) begin errors++; $display("FAIL lb_we_be got %b want 01111", {we, be}); end
    do_data(MEM_LBU, 32'h201, 32'h0, 32'h0000F000, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (rd !== 32'h000000F0) begin errors++; $display("FAIL lbu_rdata got %h want 000000f0", rd); end
    do_data(MEM_LH, 32'h202, 32'h0, 32'h80000000, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL lh_rdata got %h want ffff8000", rd); end
    do_data(MEM_LHU, 32'h200, 32'h0, 32'h1234ABCD, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_rdata got %h want 0000abcd", rd); end
    do_data(MEM_LW, 32'h208, 32'h0, 32'h76543210, rc, ac, rd, err, we, be, ma, mw);
    checks++; if ({err, rd} !== {1'b0, 32'h76543210}) begin errors++; $display("FAIL lw_rdata got %h want 076543210", {err, rd}); end
    checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL i_rdata_hold got %h want deadbeef", i_rdata); end
  endtask

  task automatic test_misaligned();
    int rc, ac; logic [31:0] rd, ma, mw; logic err, we; logic [3:0] be;
    do_data(MEM_LW, 32'h202, 32'h0, 32'h11111111, rc, ac, rd, err, we, be, ma, mw);
    checks++; if (ac !== 1) begin errors++; $display("FAIL mis_lw_ack_cycle got %0d want 1", ac); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_lw_err got %b want 1", err); end
    checks++; if (rc !== -1) begin errors++; $display("FAIL mis_lw_mem_req got cycle %0d want none", rc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata got %h want 0", rd); end
    do_data(MEM_SH, 32'h201, 32'h5555, 32'h0, rc, ac, rd, err, we, be, ma, mw);
    checks++; if ({ac, err, rc} !== {32'sd1, 1'b1, -32'sd1}) begin errors++; $display("FAIL mis_sh got ack %0d err %b req %0d want 1 1 -1", ac, err, rc); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] own;
    logic [6:0] exp_own;
    int cyc[7];
    int n, dleft;
    n = 0; dleft = 6; exp_own = 7'b1101111; own = 'x;
    for (int k = 0; k < 7; k++) cyc[k] = -100;
    mem_word = 32'h0BADF00D; i_addr = 32'h300; i_req = 1'b1;
    d_op = MEM_LW; d_addr = 32'h400; d_req = 1'b1;
    for (int c = 1; c <= 60 && n < 7; c++) begin
      @(posedge clk); #1;
      if (d_ack) begin
        own[n] = 1'b1; cyc[n] = c; n++; dleft--;
        if (dleft == 0) d_req = 1'b0;
      end else if (i_ack) begin
        own[n] = 1'b0; cyc[n] = c; n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++; if (own[k] !== exp_own[k]) begin errors++; $display("FAIL grant_order[%0d] got %b want %b (1=D)", k, own[k], exp_own[k]); end
    end
    for (int k = 1; k < 7; k++) begin
      checks++; if (cyc[k] - cyc[k-1] !== 3 + RDL) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", k, cyc[k] - cyc[k-1], 3 + RDL); end
    end
    for (int c = 0; c < 10 && busy; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_access();
    int rc, ac, acks;
    logic [31:0] rd, ma, mw; logic err, we; logic [3:0] be;
    acks = 0;
    mem_word = 32'h11223344; d_op = MEM_LW; d_addr = 32'h500; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1; d_req = 1'b0;
    #1;
    checks++; if ({mem_req, i_ack, d_ack, d_err, busy} !== 5'b0) begin errors++; $display("FAIL mid_rst_ctrl got %b want 00000", {mem_req, i_ack, d_ack, d_err, busy}); end
    checks++; if ({i_rdata, d_rdata, mem_addr, mem_wdata, mem_be, mem_we} !== 133'd0) begin errors++; $display("FAIL mid_rst_data got nonzero want 0"); end
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (d_ack || i_ack || mem_req) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL mid_no_ack got %0d events want 0", acks); end
    do_data(MEM_LW, 32'h500, 32'h0, 32'h11223344, rc, ac, rd, err, we, be, ma, mw);
    checks++; if ({ac, rd} !== {32'sd3, 32'h11223344}) begin errors++; $display("FAIL mid_reissue got ack %0d rdata %h want 3 11223344", ac, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_stores();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
